// File: rtl/seg7_scan_decoder.sv
// Recovers the hex value shown on each digit of a multiplexed 7-segment display.
// The decoder observes the segment and anode lines and captures a digit once its sample has settled.
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [N_DIGITS-1:0]   an,
  input  logic                  clr_err,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  frame_valid,
  output logic                  err_pat,
  output logic                  err_an
);

  localparam int SAMPLE_W = 7 + N_DIGITS;
  localparam logic [8:0] STABLE_TARGET = 9'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    PAT_LEGAL,
    PAT_BLANK,
    PAT_ILLEGAL
  } pat_kind_e;

  typedef struct packed {
    pat_kind_e  kind;
    logic [3:0] value;
  } pat_dec_t;

  // Segment order is {a,b,c,d,e,f,g}; both the all-dark and the lone-dash codes read as blank.
  function automatic pat_dec_t decode_seg(input logic [6:0] code);
    pat_dec_t d;
    d.kind  = PAT_LEGAL;
    d.value = 4'h0;
    case (code)
      7'b1111110: d.value = 4'h0;
      7'b0110000: d.value = 4'h1;
      7'b1101101: d.value = 4'h2;
      7'b1111001: d.value = 4'h3;
      7'b0110011: d.value = 4'h4;
      7'b1011011: d.value = 4'h5;
      7'b1011111: d.value = 4'h6;
      7'b1110000: d.value = 4'h7;
      7'b1111111: d.value = 4'h8;
      7'b1111011: d.value = 4'h9;
      7'b1110111: d.value = 4'hA;
      7'b0011111: d.value = 4'hB;
      7'b1001110: d.value = 4'hC;
      7'b0111101: d.value = 4'hD;
      7'b1001111: d.value = 4'hE;
      7'b1000111: d.value = 4'hF;
      7'b0000000,
      7'b0000001: d.kind = PAT_BLANK;
      default:    d.kind = PAT_ILLEGAL;
    endcase
    return d;
  endfunction

  logic [SAMPLE_W-1:0]   sample_q;
  logic [SAMPLE_W-1:0]   sample_d;
  logic [7:0]            dwell_q;
  logic [7:0]            dwell_d;
  logic [8:0]            dwell_inc;
  logic [N_DIGITS-1:0]   seen_q;
  logic [N_DIGITS-1:0]   seen_next;
  logic [4*N_DIGITS-1:0] digits_d;
  logic [N_DIGITS-1:0]   digit_valid_d;

  logic     same_sample;
  logic     capture_due;
  logic     an_zero;
  logic     an_multi;
  logic     an_onehot;
  logic     capture;
  logic     cap_ok;
  logic     pat_evt;
  logic     an_evt;
  logic     frame_done;
  pat_dec_t dec;

  // Dwell tracking: dwell_q counts identical samples up to the previous cycle; zero means no history.
  always_comb begin
    sample_d    = {seg, an};
    same_sample = (sample_d == sample_q) && (dwell_q != 8'd0);
    dwell_inc   = same_sample ? ({1'b0, dwell_q} + 9'd1) : 9'd1;
    capture_due = (dwell_inc == STABLE_TARGET);
    dwell_d     = (dwell_inc > STABLE_TARGET) ? STABLE_TARGET[7:0] : dwell_inc[7:0];
  end

  always_comb begin
    an_zero   = (an == '0);
    an_multi  = ((an & (an - N_DIGITS'(1))) != '0);
    an_onehot = !an_zero && !an_multi;
    dec       = decode_seg(seg);
    capture   = capture_due && an_onehot;
    pat_evt   = capture && (dec.kind == PAT_ILLEGAL);
    cap_ok    = capture && (dec.kind != PAT_ILLEGAL);
    // A multi-hot anode is reported once, when that sample first appears.
    an_evt    = an_multi && (dwell_inc == 9'd1);
  end

  // NOTE: every always_comb output gets a default before any conditional write so no latch is inferred.
  always_comb begin
    digits_d      = digits;
    digit_valid_d = digit_valid;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (cap_ok && an[i]) begin
        digits_d[4*i +: 4] = (dec.kind == PAT_LEGAL) ? dec.value : 4'h0;
        digit_valid_d[i]   = (dec.kind == PAT_LEGAL);
      end
    end
    seen_next  = seen_q | (cap_ok ? an : '0);
    frame_done = cap_ok && (&seen_next);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all state, including the sample history, is reset so a dwell never spans a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q    <= '0;
      dwell_q     <= 8'd0;
      seen_q      <= '0;
      digits      <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      err_pat     <= 1'b0;
      err_an      <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      dwell_q     <= dwell_d;
      digits      <= digits_d;
      digit_valid <= digit_valid_d;
      frame_valid <= frame_done;
      seen_q      <= frame_done ? '0 : seen_next;
      // A new error in the clearing cycle keeps its flag set.
      err_pat     <= (err_pat && !clr_err) || pat_evt;
      err_an      <= (err_an && !clr_err) || an_evt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed, table-driven bench for seg7_scan_decoder with N_DIGITS=4, STABLE_CYCLES=4.
// Each record holds inputs for a number of cycles; outputs are checked every cycle.
module tb_seg7_scan_decoder;

  localparam logic [6:0] C0   = 7'b1111110;
  localparam logic [6:0] C1   = 7'b0110000;
  localparam logic [6:0] C2   = 7'b1101101;
  localparam logic [6:0] C3   = 7'b1111001;
  localparam logic [6:0] C8   = 7'b1111111;
  localparam logic [6:0] CA   = 7'b1110111;
  localparam logic [6:0] CF   = 7'b1000111;
  localparam logic [6:0] BLK0 = 7'b0000000;
  localparam logic [6:0] BLK1 = 7'b0000001;
  localparam logic [6:0] ILL  = 7'b1010101;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        clr_err;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err_pat;
  logic        err_an;

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .clr_err     (clr_err),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err_pat     (err_pat),
    .err_an      (err_an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        clr;
    logic        rst;
    int          hold;
    logic [15:0] d;
    logic [3:0]  dv;
    logic        fv;
    logic        ep;
    logic        ea;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic [6:0] s, input logic [3:0] a, input logic c, input logic r,
                     input int h, input logic [15:0] d, input logic [3:0] dv,
                     input logic fv, input logic ep, input logic ea);
    vec_t v;
    v.seg = s; v.an = a; v.clr = c; v.rst = r; v.hold = h;
    v.d = d; v.dv = dv; v.fv = fv; v.ep = ep; v.ea = ea;
    vecs.push_back(v);
  endtask

  function automatic logic [22:0] outs();
    return {digits, digit_valid, frame_valid, err_pat, err_an};
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got digits=%h dv=%b fv=%b ep=%b ea=%b, expected digits=%h dv=%b fv=%b ep=%b ea=%b",
               name, got[22:7], got[6:3], got[2], got[1], got[0],
               exp[22:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] a, input logic c, input logic r);
    @(negedge clk);
    seg = s; an = a; clr_err = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [22:0] prev;
    logic [22:0] exp;
    int          fv_count;
    logic [15:0] fv_digits;
    logic [3:0]  fv_dv;
    logic [6:0]  seq_seg [3];
    logic [3:0]  seq_an  [3];

    seg = '0; an = '0; clr_err = 1'b0; rst = 1'b1;

    //  seg   an       clr rst hold digits    dv       fv ep ea
    add(BLK0, 4'b0000, 0,  1,  1,   16'h0000, 4'b0000, 0, 0, 0);  // reset state
    add(C1,   4'b0001, 0,  1,  1,   16'h0000, 4'b0000, 0, 0, 0);  // stable during reset
    add(C1,   4'b0001, 0,  0,  4,   16'h0001, 4'b0001, 0, 0, 0);  // basic capture
    add(C1,   4'b0001, 0,  0,  3,   16'h0001, 4'b0001, 0, 0, 0);  // held: no change
    add(C3,   4'b0001, 0,  0,  4,   16'h0003, 4'b0001, 0, 0, 0);  // digit0 update only
    add(CA,   4'b0010, 0,  0,  4,   16'h00A3, 4'b0011, 0, 0, 0);
    add(BLK0, 4'b0100, 0,  0,  4,   16'h00A3, 4'b0011, 0, 0, 0);  // blank digit2
    add(CF,   4'b1000, 0,  0,  4,   16'hF0A3, 4'b1011, 1, 0, 0);  // frame completes
    add(CF,   4'b1000, 0,  0,  2,   16'hF0A3, 4'b1011, 0, 0, 0);  // pulse is one cycle
    add(C8,   4'b0001, 0,  0,  3,   16'hF0A3, 4'b1011, 0, 0, 0);  // glitch: 3 cycles only
    add(C0,   4'b0001, 0,  0,  3,   16'hF0A3, 4'b1011, 0, 0, 0);  // count restarted
    add(C0,   4'b0001, 0,  0,  1,   16'hF0A0, 4'b1011, 0, 0, 0);  // 4th sample of new code
    add(BLK1, 4'b0010, 0,  0,  4,   16'hF000, 4'b1001, 0, 0, 0);  // dash blank clears digit1
    add(C1,   4'b0000, 0,  0,  5,   16'hF000, 4'b1001, 0, 0, 0);  // an=0: no capture
    add(ILL,  4'b0100, 0,  0,  4,   16'hF000, 4'b1001, 0, 1, 0);  // illegal pattern
    add(ILL,  4'b0100, 0,  0,  2,   16'hF000, 4'b1001, 0, 1, 0);
    add(C1,   4'b0011, 0,  0,  1,   16'hF000, 4'b1001, 0, 1, 1);  // multi-hot anode
    add(C1,   4'b0011, 0,  0,  4,   16'hF000, 4'b1001, 0, 1, 1);  // no capture
    add(C1,   4'b0011, 1,  0,  1,   16'hF000, 4'b1001, 0, 0, 0);  // clear both
    add(C1,   4'b0011, 0,  0,  1,   16'hF000, 4'b1001, 0, 0, 0);
    add(C1,   4'b0101, 1,  0,  1,   16'hF000, 4'b1001, 0, 0, 1);  // set wins over clear
    add(C1,   4'b0101, 1,  0,  1,   16'hF000, 4'b1001, 0, 0, 0);
    add(ILL,  4'b0100, 0,  0,  3,   16'hF000, 4'b1001, 0, 0, 0);
    add(ILL,  4'b0100, 1,  0,  1,   16'hF000, 4'b1001, 0, 1, 0);  // set wins over clear
    add(ILL,  4'b0100, 1,  0,  1,   16'hF000, 4'b1001, 0, 0, 0);
    add(C1,   4'b1000, 0,  0,  4,   16'h1000, 4'b1001, 0, 0, 0);  // illegal did not mark digit2
    add(C3,   4'b0100, 0,  0,  4,   16'h1300, 4'b1101, 1, 0, 0);
    add(C1,   4'b0001, 0,  0,  4,   16'h1301, 4'b1101, 0, 0, 0);  // two digits of new frame
    add(C3,   4'b0010, 0,  0,  4,   16'h1331, 4'b1111, 0, 0, 0);
    add(C3,   4'b0010, 0,  1,  1,   16'h0000, 4'b0000, 0, 0, 0);  // reset mid-frame
    add(C3,   4'b0010, 0,  0,  4,   16'h0030, 4'b0010, 0, 0, 0);
    add(CA,   4'b0100, 0,  0,  4,   16'h0A30, 4'b0110, 0, 0, 0);
    add(CF,   4'b1000, 0,  0,  4,   16'hFA30, 4'b1110, 0, 0, 0);  // mask was cleared by reset
    add(C1,   4'b0001, 0,  0,  4,   16'hFA31, 4'b1111, 1, 0, 0);
    add(C3,   4'b0011, 0,  0,  1,   16'hFA31, 4'b1111, 0, 0, 1);
    add(C3,   4'b0001, 0,  0,  3,   16'hFA31, 4'b1111, 0, 0, 1);
    add(C3,   4'b0001, 0,  1,  1,   16'h0000, 4'b0000, 0, 0, 0);  // reset beats due capture
    add(C3,   4'b0001, 0,  0,  3,   16'h0000, 4'b0000, 0, 0, 0);  // full dwell needed again
    add(C3,   4'b0001, 0,  0,  1,   16'h0003, 4'b0001, 0, 0, 0);

    prev = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].hold; c++) begin
        drive(vecs[i].seg, vecs[i].an, vecs[i].clr, vecs[i].rst);
        if (c == vecs[i].hold - 1) begin
          exp = {vecs[i].d, vecs[i].dv, vecs[i].fv, vecs[i].ep, vecs[i].ea};
          check($sformatf("vec%0d", i), outs(), exp);
        end else begin
          check($sformatf("vec%0d_hold%0d", i, c), outs(), {prev[22:3], 1'b0, prev[1:0]});
        end
      end
      prev = {vecs[i].d, vecs[i].dv, vecs[i].fv, vecs[i].ep, vecs[i].ea};
    end

    // Digit0 is already in the mask; scanning digits 1..3 must yield exactly one pulse.
    seq_seg[0] = C1; seq_an[0] = 4'b0010;
    seq_seg[1] = C2; seq_an[1] = 4'b0100;
    seq_seg[2] = C3; seq_an[2] = 4'b1000;
    fv_count  = 0;
    fv_digits = '0;
    fv_dv     = '0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        drive(seq_seg[k], seq_an[k], 1'b0, 1'b0);
        if (frame_valid) begin
          fv_count++;
          fv_digits = digits;
          fv_dv     = digit_valid;
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(C3, 4'b1000, 1'b0, 1'b0);
      if (frame_valid) fv_count++;
    end
    n_vec++;
    if (fv_count != 1) begin
      n_miss++;
      $display("FAIL scan_pulse_count: got %0d pulses, expected 1", fv_count);
    end
    n_vec++;
    if (fv_digits !== 16'h3213 || fv_dv !== 4'b1111) begin
      n_miss++;
      $display("FAIL scan_frame_value: got digits=%h dv=%b, expected digits=3213 dv=1111",
               fv_digits, fv_dv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed display digits.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..255: consecutive identical samples required before a capture.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seg, input, 7 bits: segment lines a..g, a at seg[6] and g at seg[0], active-high (lit = 1).
REQ-006 SHALL have port an, input, N_DIGITS bits: digit enables, active-high, expected one-hot; bit i selects digit i.
REQ-007 SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-008 SHALL have port digits, output, 4*N_DIGITS bits: decoded hex value; digit i occupies bits [4i+3:4i].
REQ-009 SHALL have port digit_valid, output, N_DIGITS bits: 1 = digit i holds a decoded hex value; 0 = blank or never captured.
REQ-010 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when every digit has been captured since the previous pulse.
REQ-011 SHALL have port err_pat, output, 1 bit: sticky flag; an illegal segment pattern was captured.
REQ-012 SHALL have port err_an, output, 1 bit: sticky flag; an had more than one bit set.

Function
REQ-013 SHALL decode these seg codes to hex: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, B=0011111, C=1001110, D=0111101, E=1001111, F=1000111.
REQ-014 SHALL treat 0000001 and 0000000 as blank codes: digit_valid[i] cleared, digits nibble i forced to 0, no error.
REQ-015 SHALL treat any other seg code as illegal: set err_pat, leave digits, digit_valid and the frame mask for that digit unchanged.
REQ-016 SHALL count a dwell as consecutive cycles with an identical {seg, an} sample; any change restarts the count at 1 with the new sample.
REQ-017 SHALL capture exactly once per dwell, in the cycle the STABLE_CYCLES-th identical sample is present; the result is visible on outputs the following cycle.
REQ-018 SHALL saturate the dwell counter after capture; no re-capture until {seg, an} changes.
REQ-019 SHALL, when an = 0, perform no capture and raise no error; the dwell counter still tracks the sample.
REQ-020 SHALL, when an has 2 or more bits set, perform no capture and set err_an in the cycle after that sample is first seen.
REQ-021 SHALL keep an N_DIGITS-bit seen mask; a legal or blank capture of digit i sets bit i.
REQ-022 SHALL assert frame_valid for one cycle, registered together with the capture that completes the mask, and clear the mask in that same cycle.
REQ-023 SHALL count a repeated capture of a digit already in the mask as an update only, with no effect on frame timing.
REQ-024 SHALL clear err_pat and err_an on clr_err; if clr_err coincides with a new error event, the flag SHALL remain set (set wins).
REQ-025 SHALL present only registered outputs; the decode path has no combinational route from inputs to outputs.

Reset
REQ-026 SHALL, while rst = 1 at a clock edge, set digits = 0, digit_valid = 0, frame_valid = 0, err_pat = 0, err_an = 0, seen mask = 0, and dwell counter = 0.
REQ-027 SHALL let rst override all other inputs, including a capture due in the same cycle.
REQ-028 SHALL, after reset release, require a full STABLE_CYCLES dwell before any capture, even if inputs were stable during reset.

Verification
REQ-029 SHALL verify basic capture: an=0001, seg=0110000 held 4 cycles -> from cycle 5, digits[3:0]=1 and digit_valid=0001; no further update while held.
REQ-030 SHALL verify a full frame: digits 0..3 driven in turn with codes 3, A, blank, F, each held 4 cycles -> frame_valid pulses once, 1 cycle, with digits=16'hF0A3 (nibble 1 = A, nibble 0 = 3) and digit_valid=1011.
REQ-031 SHALL verify glitch rejection: seg changes after 3 cycles of a 4-cycle requirement -> no capture, and the count restarts with the new code.
REQ-032 SHALL verify error handling: seg=1010101 held 4 cycles -> err_pat=1 and digits unchanged; an=0011 -> err_an=1; clr_err -> both 0, unless the same-cycle error rule (REQ-024) applies.
REQ-033 SHALL verify reset mid-frame: 2 digits captured, then rst for 1 cycle -> all outputs 0; the next frame_valid requires all 4 digits to be captured again.
